// File: rtl/run_ctrl.sv
// Run/stop/step controller for a small CPU: reset sequencing, breakpoint
// handling, single-step and halt, plus a saturating executed-instruction count.
module run_ctrl #(
  parameter int unsigned INIT_CYC = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       srst_i,
  input  logic       run_i,
  input  logic       stop_i,
  input  logic       step_i,
  input  logic       hlt_i,
  input  logic [3:0] pc_i,
  input  logic       bp_en_i,
  input  logic [3:0] bp_addr_i,
  output logic       cpu_en_o,
  output logic       cpu_rst_o,
  output logic [2:0] state_o,
  output logic       halted_o,
  output logic [7:0] cyc_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CYC_W = 8;

  typedef enum logic [2:0] {
    ST_INIT = 3'b000,
    ST_STOP = 3'b001,
    ST_RUN  = 3'b010,
    ST_STEP = 3'b011,
    ST_HALT = 3'b100
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] init_cnt;
  logic             skip;
  logic [CYC_W-1:0] cyc;
  logic             bp_hit;
  logic             cpu_en;

  // skip masks the breakpoint for the first executed instruction after a resume
  assign bp_hit = bp_en_i && (pc_i == bp_addr_i) && !skip;

  // CPU enable is the only combinational output
  always_comb begin
    cpu_en = 1'b0;
    case (state)
      ST_RUN:  cpu_en = !bp_hit;
      ST_STEP: cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

  // State, INIT counter, skip flag and instruction counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      skip     <= 1'b1;
      cyc      <= '0;
    end else if (srst_i) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      skip     <= 1'b1;
      cyc      <= '0;
    end else begin
      if (cpu_en && (cyc != {CYC_W{1'b1}})) begin
        cyc <= cyc + CYC_W'(1);
      end
      case (state)
        ST_INIT: begin
          if (init_cnt == CNT_W'(INIT_CYC - 1)) begin
            state <= ST_STOP;
          end else begin
            init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (run_i) begin
            state <= ST_RUN;
            skip  <= 1'b1;
          end else if (step_i) begin
            state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (cpu_en) begin
            skip <= 1'b0;
          end
          if (hlt_i && cpu_en) begin
            state <= ST_HALT;
          end else if (stop_i || bp_hit) begin
            state <= ST_STOP;
          end
        end
        ST_STEP: begin
          state <= hlt_i ? ST_HALT : ST_STOP;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  assign cpu_en_o  = cpu_en;
  assign cpu_rst_o = (state == ST_INIT);
  assign halted_o  = (state == ST_HALT);
  assign state_o   = state;
  assign cyc_o     = cyc;

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter INIT_CYC, default 2, meaning the number of cycles cpu_rst_o is held after reset release (legal range 1..15).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port srst_i, input, 1 bit: synchronous soft reset request.
REQ-005 The block SHALL have port run_i, input, 1 bit: request free-running execution.
REQ-006 The block SHALL have port stop_i, input, 1 bit: request stop.
REQ-007 The block SHALL have port step_i, input, 1 bit: request execution of exactly one instruction.
REQ-008 The block SHALL have port hlt_i, input, 1 bit: halt decode from the instruction decoder.
REQ-009 The block SHALL have port pc_i, input, 4 bits: the current program-counter value.
REQ-010 The block SHALL have port bp_en_i, input, 1 bit: breakpoint enable.
REQ-011 The block SHALL have port bp_addr_i, input, 4 bits: breakpoint address.
REQ-012 The block SHALL have port cpu_en_o, output, 1 bit: CPU clock-enable; the CPU executes one instruction per cycle in which it is 1.
REQ-013 The block SHALL have port cpu_rst_o, output, 1 bit: CPU reset.
REQ-014 The block SHALL have port state_o, output, 3 bits: current state encoding.
REQ-015 The block SHALL have port halted_o, output, 1 bit: 1 while in HALT.
REQ-016 The block SHALL have port cyc_o, output, 8 bits: count of executed instructions.

Function
REQ-017 States and encodings SHALL be INIT=000, STOP=001, RUN=010, STEP=011, HALT=100; state_o SHALL equal the registered state.
REQ-018 In INIT, cpu_rst_o SHALL be 1, cpu_en_o SHALL be 0, and an internal counter SHALL advance each cycle; after exactly INIT_CYC cycles in INIT the next state SHALL be STOP.
REQ-019 In STOP, cpu_en_o SHALL be 0; run_i SHALL cause a transition to RUN and step_i SHALL cause a transition to STEP; if both are asserted, run_i SHALL win.
REQ-020 bp_hit SHALL be defined as bp_en_i AND (pc_i == bp_addr_i) AND NOT skip.
REQ-021 In RUN, cpu_en_o SHALL be combinationally equal to NOT bp_hit.
REQ-022 In STEP, cpu_en_o SHALL be 1 and breakpoints SHALL be ignored; the next state SHALL be STOP, or HALT if hlt_i is asserted.
REQ-023 The skip flag SHALL be set on every entry into RUN and SHALL be cleared after the first RUN cycle with cpu_en_o=1, so that resuming at the breakpoint address executes that instruction.
REQ-024 In RUN, the transition priority SHALL be: hlt_i with cpu_en_o=1 goes to HALT; otherwise stop_i goes to STOP; otherwise bp_hit goes to STOP; otherwise the state stays RUN.
REQ-025 In HALT, cpu_en_o SHALL be 0 and halted_o SHALL be 1; run_i, step_i and stop_i SHALL be ignored.
REQ-026 srst_i SHALL force a transition to INIT from any state and SHALL override all other inputs; the INIT counter SHALL restart.
REQ-027 cyc_o SHALL increment by 1 on each cycle with cpu_en_o=1, SHALL saturate at 255 with no wrap, and SHALL be cleared to 0 on entry to INIT.
REQ-028 hlt_i, stop_i and step_i SHALL be level-sampled; a step_i held high SHALL produce one instruction per STOP->STEP->STOP round trip, i.e. one instruction every 2 cycles.
REQ-029 Outputs other than cpu_en_o SHALL be registered or decoded only from registered state.

Reset
REQ-030 While rst_i=1, the block SHALL hold: state INIT, INIT counter 0, skip=1, cyc_o=0, cpu_rst_o=1, cpu_en_o=0, halted_o=0, state_o=000.
REQ-031 Reset assertion SHALL take effect immediately regardless of clk_i, including mid-RUN and mid-STEP.
REQ-032 After rst_i falls, cpu_rst_o SHALL stay 1 for exactly INIT_CYC rising edges.

Verification
REQ-033 Reset release with INIT_CYC=2 SHALL give cpu_rst_o=1 for 2 cycles, then state_o=001, cpu_en_o=0, cyc_o=0.
REQ-034 In STOP, a one-cycle pulse on step_i SHALL give exactly one cycle with cpu_en_o=1, then STOP, with cyc_o=1.
REQ-035 With run_i pulsed, bp_en_i=1, bp_addr_i=5 and pc_i incrementing from 0, cpu_en_o SHALL fall in the cycle pc_i=5 and the state SHALL become STOP; a further run_i SHALL execute pc 5 and continue.
REQ-036 In RUN, hlt_i and stop_i asserted in the same cycle SHALL result in HALT with halted_o=1; a later run_i SHALL leave the state at HALT.
REQ-037 Running for 300 cycles SHALL leave cyc_o at 255; a subsequent srst_i SHALL clear it to 0 and re-enter INIT.
REQ-038 Asserting rst_i asynchronously mid-RUN SHALL drive cpu_en_o to 0 and cpu_rst_o to 1 before the next clock edge.
